mem_stream_sequencer: RTL

//   Parametrised, handshaked successor to the registered 12-way priority encoder.
//   On a start pulse it snapshots which of NCH memory blocks hold data, and how many entries each holds.
//   It then walks the non-empty blocks in priority order, issuing one read address per entry under valid/ready.

---
 rtl/mem_seq_pkg.sv | 33 +++
 rtl/mem_seq_prio_pick.sv | 32 +++
 rtl/mem_stream_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types, defaults and helpers for the memory stream sequencer.
// Optional feature macro used by the top: MEM_SEQ_ROUND_ROBIN_EN.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int DEF_NCH = 12;
    localparam int DEF_AW  = 6;

    // Widest one-hot vector the encoder helper accepts; NCH must not exceed this.
    localparam int OH_MAX = 64;

    function automatic int unsigned clamp_count(input int unsigned n, input int unsigned lim);
        return (n > lim) ? lim : n;
    endfunction

    function automatic int unsigned onehot_to_bin(input logic [OH_MAX-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < OH_MAX; i++) begin
            if (oh[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_seq_prio_pick.sv
// Combinational rotated priority pick: first set bit of pending at or above base, wrapping.
module mem_seq_prio_pick
    import mem_seq_pkg::*;
#(
    parameter  int NCH = DEF_NCH,
    localparam int SW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] pending,
    input  logic [SW-1:0]  base,
    output logic           any,
    output logic [SW-1:0]  idx,
    output logic [NCH-1:0] onehot
);

    // Walk the blocks starting at base and keep the first pending one found.
    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        any    = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            j = (int'(base) + k) % NCH;
            if (!any && pending[j]) begin
                onehot[j] = 1'b1;
                any       = 1'b1;
            end
        end
    end

    assign idx = SW'(onehot_to_bin(OH_MAX'(onehot)));

endmodule

// File: rtl/mem_stream_sequencer.sv
// Snapshot per-block occupancy on start, then stream one read address per entry
// of every non-empty block in priority order under valid/ready; pulse done at the end.
// Optional feature macro: MEM_SEQ_ROUND_ROBIN_EN (rotating start block between passes).
module mem_stream_sequencer
    import mem_seq_pkg::*;
#(
    parameter  int NCH = DEF_NCH,
    parameter  int AW  = DEF_AW,
    localparam int SW  = $clog2(NCH),
    localparam int CW  = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NCH-1:0]    has_dat,
    input  logic [NCH*CW-1:0] nent,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [SW-1:0]     rd_sel,
    output logic [NCH-1:0]    rd_sel_oh,
    output logic [AW-1:0]     rd_addr,
    output logic              rd_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned MAX_ENT = 32'd1 << AW;

    state_e          state_q, state_d;
    logic [NCH-1:0]  pending_q, pending_d;
    logic [CW-1:0]   cnt_q [NCH];
    logic [CW-1:0]   cnt_d [NCH];
    logic            rd_valid_q, rd_valid_d;
    logic [SW-1:0]   rd_sel_q, rd_sel_d;
    logic [NCH-1:0]  rd_sel_oh_q, rd_sel_oh_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic            rd_last_q, rd_last_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [SW-1:0]   rr_base;
    logic            pick_any;
    logic [SW-1:0]   pick_idx;
    logic [NCH-1:0]  pick_oh;
    logic [CW-1:0]   cur_cnt;
    logic [CW-1:0]   pick_cnt;

    assign cur_cnt  = cnt_q[rd_sel_q];
    assign pick_cnt = cnt_q[pick_idx];

    mem_seq_prio_pick #(.NCH(NCH)) u_pick (
        .pending (pending_q),
        .base    (rr_base),
        .any     (pick_any),
        .idx     (pick_idx),
        .onehot  (pick_oh)
    );

`ifdef MEM_SEQ_ROUND_ROBIN_EN
    logic [SW-1:0] rr_base_q, rr_base_d;
    logic [SW-1:0] first_q, first_d;
    logic          served_q, served_d;

    assign rr_base = rr_base_q;

    // Remember the first block serviced in a pass and rotate the base past it at the end.
    always_comb begin
        rr_base_d = rr_base_q;
        first_d   = first_q;
        served_d  = served_q;
        if (state_q == ST_IDLE && start) begin
            served_d = 1'b0;
        end
        if (state_q == ST_SCAN && pick_any && !served_q) begin
            first_d  = pick_idx;
            served_d = 1'b1;
        end
        if (state_q == ST_DONE && served_q) begin
            rr_base_d = (first_q == SW'(NCH - 1)) ? '0 : first_q + SW'(1);
        end
    end

    // Round-robin bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_base_q <= '0;
            first_q   <= '0;
            served_q  <= 1'b0;
        end else begin
            rr_base_q <= rr_base_d;
            first_q   <= first_d;
            served_q  <= served_d;
        end
    end
`else
    assign rr_base = '0;
`endif

    // Next-state logic for the pass FSM and its registered outputs.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        cnt_d       = cnt_q;
        rd_valid_d  = rd_valid_q;
        rd_sel_d    = rd_sel_q;
        rd_sel_oh_d = rd_sel_oh_q;
        rd_addr_d   = rd_addr_q;
        rd_last_d   = rd_last_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int i = 0; i < NCH; i++) begin
                        pending_d[i] = has_dat[i] & (nent[i*CW +: CW] != '0);
                        cnt_d[i]     = CW'(clamp_count(32'(nent[i*CW +: CW]), MAX_ENT));
                    end
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (pick_any) begin
                    state_d     = ST_READ;
                    rd_valid_d  = 1'b1;
                    rd_sel_d    = pick_idx;
                    rd_sel_oh_d = pick_oh;
                    rd_addr_d   = '0;
                    rd_last_d   = (pick_cnt == CW'(1));
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_READ: begin
                if (rd_ready) begin
                    if (rd_last_q) begin
                        pending_d[rd_sel_q] = 1'b0;
                        state_d     = ST_SCAN;
                        rd_valid_d  = 1'b0;
                        rd_sel_d    = '0;
                        rd_sel_oh_d = '0;
                        rd_addr_d   = '0;
                        rd_last_d   = 1'b0;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                        rd_last_d = (({1'b0, rd_addr_q} + CW'(2)) == cur_cnt);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            cnt_q       <= '{default: '0};
            rd_valid_q  <= 1'b0;
            rd_sel_q    <= '0;
            rd_sel_oh_q <= '0;
            rd_addr_q   <= '0;
            rd_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            rd_valid_q  <= rd_valid_d;
            rd_sel_q    <= rd_sel_d;
            rd_sel_oh_q <= rd_sel_oh_d;
            rd_addr_q   <= rd_addr_d;
            rd_last_q   <= rd_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_sel    = rd_sel_q;
    assign rd_sel_oh = rd_sel_oh_q;
    assign rd_addr   = rd_addr_q;
    assign rd_last   = rd_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
